branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: latches a decoded branch, resolves it against the
// registered ALU flags, pulses the PC load and holds a short flush window when taken.
module branch_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [3:0]        FlagIn,
    input  logic              FlagWe,
    input  logic              BrReq,
    input  logic [1:0]        BrCond,
    input  logic [ADDR_W-1:0] BrTarget,
    output logic [3:0]        Flag,
    output logic              Stall,
    output logic              BrAck,
    output logic              Taken,
    output logic              PcLoad,
    output logic [ADDR_W-1:0] PcTarget,
    output logic              Flush,
    output logic [7:0]        TakenCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          flag_q, flag_d;
    logic [1:0]          cond_q, cond_d;
    logic [ADDR_W-1:0]   target_q, target_d;
    logic [2:0]          flush_cnt_q, flush_cnt_d;
    logic [7:0]          taken_cnt_q, taken_cnt_d;
    logic                cond_true;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= IDLE;
            flag_q      <= 4'd0;
            cond_q      <= 2'd0;
            target_q    <= '0;
            flush_cnt_q <= 3'd0;
            taken_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            cond_q      <= cond_d;
            target_q    <= target_d;
            flush_cnt_q <= flush_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    // Flags are written independently of the branch FSM.
    assign flag_d = FlagWe ? FlagIn : flag_q;

    always_comb begin
        case (cond_q)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = flag_q[2];
            2'b10:   cond_true = ~flag_q[3];
            default: cond_true = flag_q[3];
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        target_d    = target_q;
        flush_cnt_d = flush_cnt_q;
        taken_cnt_d = taken_cnt_q;
        Stall       = 1'b0;
        BrAck       = 1'b0;
        Taken       = 1'b0;
        PcLoad      = 1'b0;
        Flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (BrReq) begin
                    cond_d   = BrCond;
                    target_d = BrTarget;
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                Stall = 1'b1;
                // A flag write this cycle means the flags are not yet final; wait.
                if (!FlagWe) begin
                    BrAck = 1'b1;
                    Taken = cond_true;
                    if (cond_true) begin
                        PcLoad      = 1'b1;
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                        if (taken_cnt_q != 8'hFF) begin
                            taken_cnt_d = taken_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                Stall       = 1'b1;
                Flush       = 1'b1;
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Flag       = flag_q;
    assign PcTarget   = target_q;
    assign TakenCount = taken_cnt_q;

endmodule
